// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-entry busy scoreboard and a counter-driven
// clear sequencer that zeroes the array after reset or on request before raising ready.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear_req,
    output logic                             ready,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             issue_en,
    input  logic [ADDR_WIDTH-1:0]            issue_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_READ-1:0]              rd_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    wr_valid;
    logic                    issue_valid;

    // A clear request in the same cycle discards any writeback or issue.
    always_comb begin
        wr_valid    = (state_q == READY) && !clear_req && wr_en &&
                      !((ZERO_REG != 0) && (wr_addr == '0));
        issue_valid = (state_q == READY) && !clear_req && issue_en &&
                      !((ZERO_REG != 0) && (issue_addr == '0));
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                if (clear_req) begin
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
                    if (clr_idx_q == LAST_IDX) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                    busy_d    = '0;
                end else begin
                    if (wr_valid) begin
                        mem_we          = 1'b1;
                        busy_d[wr_addr] = 1'b0;
                    end
                    // Issue is applied after the write so a same-address issue keeps busy set.
                    if (issue_valid) begin
                        busy_d[issue_addr] = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            ready_q   <= 1'b0;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // The array has no reset; the sequencer is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
            rd_busy[k]                          = busy_q[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
            if ((BYPASS != 0) && wr_valid && (wr_addr == rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                rd_busy[k]                          = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy[k]                          = 1'b0;
            end
            if (state_q != READY) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy[k]                          = 1'b0;
            end
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (4 read ports): directed vector table, clear/reset
// timing sequences and randomized traffic checked against an array-based model.
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    typedef struct {
        logic                 clr;
        logic                 we;
        logic [AW-1:0]        wa;
        logic [DW-1:0]        wd;
        logic                 ie;
        logic [AW-1:0]        ia;
        logic [NR-1:0][AW-1:0] ra;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 clear_req = 1'b0;
    logic                 ready;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [DW-1:0]        wr_data = '0;
    logic                 issue_en = 1'b0;
    logic [AW-1:0]        issue_addr = '0;
    logic [NR*AW-1:0]     rd_addr = '0;
    logic [NR*DW-1:0]     rd_data;
    logic [NR-1:0]        rd_busy;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    int            m_remaining;

    int   errors = 0;
    int   checks = 0;
    int   n;
    vec_t vecs [11];

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy)
    );

    function automatic void checkVal(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic stim_t mkStim(logic clr, logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                     logic ie, logic [AW-1:0] ia, logic [AW-1:0] r0,
                                     logic [AW-1:0] r1, logic [AW-1:0] r2, logic [AW-1:0] r3);
        stim_t s;
        s.clr = clr; s.we = we; s.wa = wa; s.wd = wd; s.ie = ie; s.ia = ia;
        s.ra[0] = r0; s.ra[1] = r1; s.ra[2] = r2; s.ra[3] = r3;
        return s;
    endfunction

    function automatic void modelReset();
        m_remaining = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Clearing is modelled as a countdown; contents are unreadable until it ends, so zero them up front.
    function automatic void modelEdge();
        if (!reset_n) return;
        if (m_remaining > 0) begin
            m_remaining = clear_req ? DEPTH : m_remaining - 1;
        end else if (clear_req) begin
            modelReset();
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endfunction

    function automatic void expectRead(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
        if (m_remaining != 0 || !reset_n || a == 0) begin
            d = '0; b = 1'b0;
        end else if (wr_en && !clear_req && wr_addr != 0 && wr_addr == a) begin
            d = wr_data; b = 1'b0;
        end else begin
            d = m_mem[a]; b = m_busy[a];
        end
    endfunction

    function automatic void checkOutput(string tag);
        logic [DW-1:0] d;
        logic          b;
        checkVal({tag, " ready"}, {31'b0, ready}, {31'b0, (m_remaining == 0) && reset_n});
        for (int k = 0; k < NR; k++) begin
            expectRead(rd_addr[k*AW +: AW], d, b);
            checkVal($sformatf("%s p%0d data", tag, k), rd_data[k*DW +: DW], d);
            checkVal($sformatf("%s p%0d busy", tag, k), {31'b0, rd_busy[k]}, {31'b0, b});
        end
    endfunction

    task automatic applyStimulus(input stim_t s);
        clear_req  = s.clr;
        wr_en      = s.we;
        wr_addr    = s.wa;
        wr_data    = s.wd;
        issue_en   = s.ie;
        issue_addr = s.ia;
        rd_addr    = s.ra;
        #1;
    endtask

    task automatic runCycle(string tag);
        checkOutput(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic randomStim(output stim_t s, input logic allow_clear);
        s = mkStim(allow_clear && ($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
                   $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom));
    endtask

    task automatic countToReady(string tag);
        stim_t s;
        n = 0;
        while (!ready && n < 100) begin
            randomStim(s, 1'b0);
            applyStimulus(s);
            runCycle(tag);
            n++;
        end
        checkVal({tag, " edges"}, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;

        vecs[0]  = '{mkStim(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 1, 2, 3), 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{mkStim(0, 0, 0, 0, 0, 0, 5, 5, 0, 31), 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{mkStim(0, 0, 0, 0, 1, 7, 7, 5, 7, 7), 32'h0, 1'b0};
        vecs[3]  = '{mkStim(0, 0, 0, 0, 0, 0, 7, 7, 5, 0), 32'h0, 1'b1};
        vecs[4]  = '{mkStim(0, 1, 7, 32'h1234, 0, 0, 7, 7, 5, 9), 32'h1234, 1'b0};
        vecs[5]  = '{mkStim(0, 0, 0, 0, 0, 0, 7, 9, 7, 5), 32'h1234, 1'b0};
        vecs[6]  = '{mkStim(0, 1, 9, 32'h55AA, 1, 9, 9, 9, 7, 5), 32'h55AA, 1'b0};
        vecs[7]  = '{mkStim(0, 0, 0, 0, 0, 0, 9, 9, 7, 5), 32'h55AA, 1'b1};
        vecs[8]  = '{mkStim(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 9, 0, 7), 32'h0, 1'b0};
        vecs[9]  = '{mkStim(0, 0, 0, 0, 1, 0, 0, 0, 9, 5), 32'h0, 1'b0};
        vecs[10] = '{mkStim(0, 0, 0, 0, 0, 0, 0, 5, 7, 9), 32'h0, 1'b0};

        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] initial clear sequence");
        for (int i = 0; i < DEPTH; i++) begin
            s = mkStim(0, 1, 5'(i | 1), 32'hA5A5A5A5, 1, 5'(i | 2), 5'(i), 5'(31 - i), 5'(i + 1), 5);
            applyStimulus(s);
            checkVal($sformatf("clear ready c%0d", i), {31'b0, ready}, 32'h0);
            runCycle("clear");
        end
        checkVal("ready after 32 edges", {31'b0, ready}, 32'h1);
        for (int a = 0; a < DEPTH; a += NR) begin
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3)));
            checkVal($sformatf("post-clear zero x%0d", a), rd_data[DW-1:0], 32'h0);
            checkVal($sformatf("post-clear busy x%0d", a + 3), {28'b0, rd_busy}, 32'h0);
            runCycle("post-clear");
        end

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].s);
            checkVal($sformatf("vec%0d data", i), rd_data[DW-1:0], vecs[i].exp_data);
            checkVal($sformatf("vec%0d busy", i), {31'b0, rd_busy[0]}, {31'b0, vecs[i].exp_busy});
            runCycle($sformatf("vec%0d", i));
        end

        $display("[TB] independent read ports");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(mkStim(0, 1, 5'(i), 32'h1000 + i, 0, 0, 0, 0, 0, 0));
            runCycle("port fill");
        end
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 4, 3, 2, 1));
        for (int k = 0; k < NR; k++)
            checkVal($sformatf("port%0d distinct", k), rd_data[k*DW +: DW], 32'h1000 + 4 - k);
        runCycle("ports");

        $display("[TB] clear request with busy entry");
        applyStimulus(mkStim(0, 1, 3, 32'hAA, 0, 0, 3, 0, 0, 0));
        runCycle("x3 write");
        applyStimulus(mkStim(0, 0, 0, 0, 1, 3, 3, 0, 0, 0));
        runCycle("x3 issue");
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        checkVal("x3 before clear data", rd_data[DW-1:0], 32'hAA);
        checkVal("x3 before clear busy", {31'b0, rd_busy[0]}, 32'h1);
        runCycle("x3 before clear");
        applyStimulus(mkStim(1, 1, 3, 32'hBB, 1, 4, 3, 4, 0, 0));
        checkVal("clear cycle no bypass", rd_data[DW-1:0], 32'hAA);
        runCycle("clear req");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mkStim(0, 1, 3, 32'hCC, 1, 3, 3, 4, 0, 0));
            checkVal($sformatf("reclear ready c%0d", i), {31'b0, ready}, 32'h0);
            runCycle("reclear");
        end
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 3, 4, 0, 0));
        checkVal("reclear ready", {31'b0, ready}, 32'h1);
        checkVal("reclear x3 data", rd_data[DW-1:0], 32'h0);
        checkVal("reclear x3 busy", {31'b0, rd_busy[0]}, 32'h0);
        runCycle("reclear done");

        $display("[TB] clear request while clearing restarts");
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 1, 2, 3, 4));
        runCycle("enter clear");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 2, 3, 4));
            runCycle("partial clear");
        end
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 1, 2, 3, 4));
        runCycle("restart clear");
        countToReady("restart via clear_req");

        $display("[TB] async reset while ready and mid-clear");
        applyStimulus(mkStim(0, 0, 0, 0, 1, 2, 2, 0, 0, 0));
        runCycle("issue x2");
        reset_n = 1'b0;
        modelReset();
        #1;
        checkVal("async reset drops ready", {31'b0, ready}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
            runCycle("clear to idx10");
        end
        reset_n = 1'b0;
        modelReset();
        #1;
        checkVal("reset mid-clear ready", {31'b0, ready}, 32'h0);
        runCycle("held reset");
        runCycle("held reset");
        reset_n = 1'b1;
        countToReady("restart after reset");
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        checkVal("x2 busy after reset", {31'b0, rd_busy[0]}, 32'h0);
        runCycle("after reset");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            randomStim(s, 1'b1);
            applyStimulus(s);
            runCycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
